// File: rtl/dmem_ctrl.sv
// Data-memory controller: single-port, synchronous-read, byte-writable word RAM behind valid/ready.
// Word-crossing accesses are split into two RAM operations when MEM_MISALIGN_EN is defined, else rejected via resp_err.
module dmem_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic        req_se,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

`ifdef MEM_MISALIGN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, RD2 = 2'd2, WR2 = 2'd3} state_t;
  localparam logic [DEPTH_LOG2-1:0] ONE = 1;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_t;
`endif

  state_t                state_q;
  logic                  ready_q, valid_q, err_q;
  logic [1:0]            off_q;
  logic [3:0]            mask_q;
  logic                  se_q, write_q;
  logic [31:0]           ram_q, rdata_hold_q;
`ifdef MEM_MISALIGN_EN
  logic                  cross_q;
  logic [DEPTH_LOG2-1:0] w2_q;
  logic [3:0]            hi_be_q;
  logic [31:0]           hi_wdata_q, hold_q;
`endif

  logic [DEPTH_LOG2-1:0] req_w;
  logic [1:0]            req_off;
  logic [3:0]            req_mask;
  logic                  req_cross, accept;
  logic [7:0]            req_be8;
  logic [63:0]           req_wd64;

  assign req_w    = req_addr[DEPTH_LOG2+1:2];
  assign req_off  = req_addr[1:0];
  assign accept   = (state_q == IDLE) && req_valid;
  assign req_be8  = {4'b0000, req_mask} << req_off;
  assign req_wd64 = {32'h0, req_wdata} << {req_off, 3'b000};

  always_comb begin
    req_mask = 4'b1111;
    if (req_size[0])      req_mask = 4'b0001;
    else if (req_size[1]) req_mask = 4'b0011;
    req_cross = ((req_mask == 4'b0011) && (req_off == 2'd3)) ||
                ((req_mask == 4'b1111) && (req_off != 2'd0));
  end

  // Single RAM port: word1 is addressed straight from the request, word2 from latched state.
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [3:0]            ram_be;
  logic [31:0]           ram_wdata;
  logic                  ram_rd;

  always_comb begin
    ram_addr  = req_w;
    ram_be    = '0;
    ram_wdata = req_wd64[31:0];
    ram_rd    = 1'b0;
    if (accept) begin
`ifdef MEM_MISALIGN_EN
      if (req_write) ram_be = req_be8[3:0];
`else
      if (req_write && !req_cross) ram_be = req_be8[3:0];
`endif
      ram_rd = !req_write;
    end
`ifdef MEM_MISALIGN_EN
    if (state_q == RD2) begin
      ram_addr = w2_q;
      ram_rd   = 1'b1;
    end
    if (state_q == WR2) begin
      ram_addr  = w2_q;
      ram_be    = hi_be_q;
      ram_wdata = hi_wdata_q;
    end
`endif
    if (reset) ram_be = '0;
  end

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  // Load assembly: {word2, word1} shifted down by the byte offset, then sized and extended.
  logic [31:0] lo_word, asm_data;
  logic [63:0] sh64;

  always_comb begin
`ifdef MEM_MISALIGN_EN
    lo_word = cross_q ? hold_q : ram_q;
`else
    lo_word = ram_q;
`endif
    sh64     = {ram_q, lo_word} >> {off_q, 3'b000};
    asm_data = sh64[31:0];
    if (mask_q == 4'b0001)      asm_data = {{24{se_q & sh64[7]}}, sh64[7:0]};
    else if (mask_q == 4'b0011) asm_data = {{16{se_q & sh64[15]}}, sh64[15:0]};
    if (write_q || err_q) asm_data = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            ready_q <= 1'b0;
            off_q   <= req_off;
            mask_q  <= req_mask;
            se_q    <= req_se;
            write_q <= req_write;
`ifdef MEM_MISALIGN_EN
            cross_q    <= req_cross;
            w2_q       <= req_w + ONE;
            hi_be_q    <= req_be8[7:4];
            hi_wdata_q <= req_wd64[63:32];
            if (req_cross) begin
              state_q <= req_write ? WR2 : RD2;
            end else begin
              state_q <= RESP;
              valid_q <= 1'b1;
            end
`else
            state_q <= RESP;
            valid_q <= 1'b1;
            err_q   <= req_cross;
`endif
          end
        end
`ifdef MEM_MISALIGN_EN
        RD2: begin
          hold_q  <= ram_q;
          state_q <= RESP;
          valid_q <= 1'b1;
        end
        WR2: begin
          state_q <= RESP;
          valid_q <= 1'b1;
        end
`endif
        RESP: begin
          rdata_hold_q <= asm_data;
          state_q      <= IDLE;
          ready_q      <= 1'b1;
          valid_q      <= 1'b0;
          err_q        <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_err   = err_q;
  assign resp_rdata = valid_q ? asm_data : rdata_hold_q;

  logic unused_bits;
`ifdef MEM_MISALIGN_EN
  assign unused_bits = ^{req_addr[31:DEPTH_LOG2+2], req_size[2], sh64[63:32]};
`else
  assign unused_bits = ^{req_addr[31:DEPTH_LOG2+2], req_size[2], sh64[63:32],
                         req_be8[7:4], req_wd64[63:32]};
`endif

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller for the RV32C core. It replaces the combinational dual-word data memory with a single-port, synchronous-read, byte-writable word RAM behind a valid/ready request interface. Misaligned accesses that cross a word boundary are split into two sequential word operations by a small state machine. It sits between the core's load/store datapath and the data RAM, and lets the core stall on multi-cycle accesses.

## Interface
- DEPTH_LOG2, 9, log2 of RAM depth in 32-bit words (default 512 words = 2 KiB)
- clock  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; bits [DEPTH_LOG2+1:2] select the word, higher bits are ignored
- req_size  in  3  one-hot size: bit0 = 1 byte, bit1 = 2 bytes, bit2 = 4 bytes
- req_se  in  1  sign-extend loads of 1 or 2 bytes
- req_wdata  in  32  store data, little-endian, LSB-aligned
- resp_valid  out  1  one-cycle pulse marking completion of the accepted request
- resp_rdata  out  32  load result, valid while resp_valid is high
- resp_err  out  1  set together with resp_valid when a misaligned access was rejected

## Operation
- Size decode uses priority: bit0 gives 1 byte, else bit1 gives 2 bytes, else 4 bytes. Illegal encodings, including 0, are treated as 4 bytes.
- A request is a crossing access when the size is 2 and addr[1:0]==3, or the size is 4 and addr[1:0]!=0. 1-byte accesses never cross.
- Word index w = addr[DEPTH_LOG2+1:2]. The second word of a crossing access is (w+1) mod 2^DEPTH_LOG2, so the last word wraps to word 0.
- Stores write only the addressed bytes through per-byte enables. Bytes outside the access are preserved, and no read-modify-write is performed.
- Loads assemble bytes little-endian across word1 and word2. 1- and 2-byte results are zero-extended, or sign-extended when req_se=1. req_se is ignored for 4-byte loads.
- The controller latches addr, size, se, write and wdata at acceptance. Inputs are not sampled again for the rest of the operation.
- State machine:
  - IDLE: req_ready=1. On req_valid, the request is accepted. A non-crossing request goes to RESP. A crossing load goes to RD2. A crossing store goes to WR2.
  - RD2: word1 read data is captured into a hold register, word2 is read, then the machine goes to RESP.
  - WR2: the upper bytes are written to word2, then the machine goes to RESP.
  - RESP: resp_valid=1, then the machine returns to IDLE.
- req_ready is 1 only in IDLE.
- resp_rdata is 0 for stores. It holds its last value between responses.
- Memory contents are not initialised or cleared by reset.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Acceptance happens at edge E0. The word1 RAM read or write happens at E0.
- Non-crossing access: resp_valid in cycle 1. The earliest next acceptance is cycle 2.
- Crossing access: the word2 read or write happens at E1. resp_valid is in cycle 2. The earliest next acceptance is cycle 3.
- RAM read latency is 1 cycle, and there is no combinational path from req_addr to resp_rdata.
- Reset asserted mid-operation forces IDLE on that edge:
  - A pending WR2 is aborted; word1 bytes already written remain.
  - No resp_valid is generated for the aborted request.
- req_valid while req_ready=0 is ignored. The requester must hold the request until it is accepted.

## Configuration
- MEM_MISALIGN_EN defined: crossing accesses are split as described, and resp_err is always 0.
- MEM_MISALIGN_EN undefined:
  - The RD2 and WR2 states are not built.
  - A crossing request is accepted and goes straight to RESP with resp_err=1 and resp_rdata=0.
  - No RAM write occurs for a rejected crossing request.
  - Non-crossing accesses behave identically in both builds.

## Test plan
- Store 4 bytes 0x11223344 at addr 0x10, then load 4 bytes at 0x10. Required: resp_rdata=0x11223344, and each resp_valid comes exactly 1 cycle after acceptance.
- Preload word0=0xAABBCCDD. Store 1 byte 0x55 at 0x2, then load 4 bytes at 0x0. Required: 0xAA55CCDD.
- Preload word0=0x80FF0000. Load 2 bytes at 0x2 with se=1, giving 0xFFFF80FF. Load 2 bytes at 0x2 with se=0, giving 0x000080FF. Load 1 byte at 0x3 with se=1, giving 0xFFFFFF80.
- With MEM_MISALIGN_EN defined, words 4 and 5 are 0. Store 4 bytes 0xDEADBEEF at 0x13, then load 4 bytes at 0x13. Required:
  - resp_rdata=0xDEADBEEF.
  - word4=0xEF000000 and word5=0x00DEADBE.
  - resp_valid 2 cycles after acceptance.
- With DEPTH_LOG2=9 and MEM_MISALIGN_EN defined, store 2 bytes 0x1234 at 0x7FF. Required: the top byte of word 511 is 0x34 and the low byte of word 0 is 0x12. Then assert reset during WR2 of a second crossing store. Required: no resp_valid, req_ready=1 the next cycle, and word2 unchanged.
- With MEM_MISALIGN_EN undefined, store 4 bytes at 0x21. Required: resp_valid with resp_err=1 in cycle 1, and words 8 and 9 unchanged.
